dummy_adc_gen: RTL

Synthetic ADC sample source that sits directly upstream of dummy_adc and drives its S_AXIS slave port.
- Generates 32-bit samples at a programmable rate, in one of four selectable patterns.
- Buffers samples in a small FWFT FIFO and presents them on an AXI4-Stream master.
- Reports dropped-sample overflow and generated-sample counts for software readback through the dummy_adc register bank.

---
 rtl/dummy_adc_pkg.sv | 31 +++
 rtl/dummy_adc_gen_fifo.sv | 72 +++++++
 rtl/dummy_adc_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dummy_adc_pkg.sv
// Shared constants and helpers for the synthetic ADC sample generator.
// Holds the pattern-mode encodings, the LFSR seed/taps and small pure
// functions used to build sample words.
package dummy_adc_pkg;

    typedef logic [1:0] adc_mode_t;

    localparam adc_mode_t MODE_RAMP  = 2'd0;
    localparam adc_mode_t MODE_CONST = 2'd1;
    localparam adc_mode_t MODE_LFSR  = 2'd2;
    localparam adc_mode_t MODE_ALT   = 2'd3;

    localparam logic [31:0] LFSR_SEED = 32'h00000001;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    // Galois step for x^32+x^22+x^2+x+1, shifting right.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state);
        logic [31:0] shifted;
        shifted = state >> 1;
        if (state[0]) begin
            shifted = shifted ^ LFSR_TAPS;
        end
        return shifted;
    endfunction

    // Ramp word carries the complement of the sequence number in the upper half.
    function automatic logic [31:0] ramp_word(input logic [15:0] seq);
        return {~seq, seq};
    endfunction

endpackage

// File: rtl/dummy_adc_gen_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is always
// visible on rd_data while the FIFO is non-empty; rd_data reads as zero
// when empty. A synchronous flush empties it in one cycle.
module dummy_adc_gen_fifo #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_L);
    assign level = count;

    // A read frees a slot in the same cycle, so a full FIFO can accept a write alongside a read.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush discards everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because empty masks the output.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/dummy_adc_gen.sv
// Synthetic ADC sample source. A programmable divider produces sample
// ticks; each tick builds a word from the selected pattern generator and
// pushes it into a small FWFT FIFO that feeds an AXI4-Stream master.
// Dropped samples and generated ticks are counted for software readback.
module dummy_adc_gen #(
    parameter int C_DIV_WIDTH = 16,
    parameter int C_FIFO_AW   = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   ctrl_enable,
    input  logic [1:0]             ctrl_mode,
    input  logic [C_DIV_WIDTH-1:0] ctrl_divider,
    input  logic [31:0]            ctrl_const,
    input  logic                   ctrl_clear,
    output logic [31:0]            m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   stat_overflow,
    output logic [15:0]            stat_drop_count,
    output logic [31:0]            stat_sample_count,
    output logic [C_FIFO_AW:0]     fifo_level
);

    import dummy_adc_pkg::*;

    logic [C_DIV_WIDTH-1:0] div_cnt;
    logic                   tick;
    logic                   gen_tick;

    logic [15:0]            seq;
    logic [31:0]            lfsr;
    logic                   alt_phase;
    logic [31:0]            sample;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   push;
    logic                   drop;

    // A tick fires on the cycle the count matches the programmed period.
    assign tick     = ctrl_enable && (div_cnt == ctrl_divider);
    // Clear wins over a coincident tick, which is then neither stored nor counted.
    assign gen_tick = tick && !ctrl_clear;

    // Divider counter; held at zero while disabled and wraps naturally if the period shrinks below it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            div_cnt <= '0;
        end else if (ctrl_clear || !ctrl_enable || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Pattern state; each generator only steps on ticks taken in its own mode.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            seq       <= '0;
            lfsr      <= LFSR_SEED;
            alt_phase <= 1'b0;
        end else if (ctrl_clear) begin
            seq       <= '0;
            lfsr      <= LFSR_SEED;
            alt_phase <= 1'b0;
        end else if (gen_tick) begin
            case (ctrl_mode)
                MODE_RAMP: seq       <= seq + 1'b1;
                MODE_LFSR: lfsr      <= lfsr_next(lfsr);
                MODE_ALT:  alt_phase <= ~alt_phase;
                default:   ;
            endcase
        end
    end

    // Sample word from the current pattern state; registered only via the FIFO.
    always_comb begin
        sample = '0;
        case (ctrl_mode)
            MODE_RAMP:  sample = ramp_word(seq);
            MODE_CONST: sample = ctrl_const;
            MODE_LFSR:  sample = lfsr;
            MODE_ALT:   sample = alt_phase ? ~ctrl_const : ctrl_const;
            default:    sample = '0;
        endcase
    end

    assign pop  = m_axis_tvalid && m_axis_tready;
    assign push = gen_tick && (!fifo_full || pop);
    assign drop = gen_tick && fifo_full && !pop;

    dummy_adc_gen_fifo #(
        .DW (32),
        .AW (C_FIFO_AW)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .flush   (ctrl_clear),
        .wr_en   (push),
        .wr_data (sample),
        .rd_en   (pop),
        .rd_data (m_axis_tdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign m_axis_tvalid = !fifo_empty;

    // Status counters: sticky overflow, saturating drop count, wrapping tick count.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_overflow     <= 1'b0;
            stat_drop_count   <= '0;
            stat_sample_count <= '0;
        end else if (ctrl_clear) begin
            stat_overflow     <= 1'b0;
            stat_drop_count   <= '0;
            stat_sample_count <= '0;
        end else begin
            if (gen_tick) begin
                stat_sample_count <= stat_sample_count + 1'b1;
            end
            if (drop) begin
                stat_overflow <= 1'b1;
                if (stat_drop_count != 16'hFFFF) begin
                    stat_drop_count <= stat_drop_count + 1'b1;
                end
            end
        end
    end

endmodule
